// File: rtl/hex_dump_tx.sv
// hex_dump_tx: buffers incoming bytes in a small FIFO and sends each one to a
// UART transmitter as two uppercase hex characters plus a separator (space, or
// CR LF at end of line). A flush request terminates a partial line.
module hex_dump_tx #(
   parameter int FIFO_DEPTH     = 4,
   parameter int BYTES_PER_LINE = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       overflow,
   input  logic       flush,
   output logic       tx_en,
   output logic [7:0] tx_data,
   input  logic       tx_busy,
   output logic       idle
);

   localparam int         AW  = $clog2(FIFO_DEPTH);
   localparam logic [7:0] BPL = 8'(BYTES_PER_LINE);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_ARM, S_WAIT} state_t;
   typedef enum logic [2:0] {C_HI, C_LO, C_SP, C_CR, C_LF} char_t;

   // FIFO storage and pointers (one extra pointer bit distinguishes full from empty)
   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        fifo_full, fifo_empty, fifo_wr, fifo_rd;

   // Formatter state
   state_t      state_q, state_d;
   char_t       char_q, char_d;
   logic [7:0]  byte_q;
   logic [7:0]  col_q, col_d;
   logic [1:0]  arm_cnt_q, arm_cnt_d;
   logic        flush_pend_q, flush_pend_d, flush_clr;
   logic        tx_en_q, tx_en_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        overflow_q, overflow_d;
   logic        advance;
   logic [7:0]  cur_char;
   logic [7:0]  col_inc;

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign in_ready   = ~fifo_full;
   assign fifo_wr    = in_valid & ~fifo_full;
   assign overflow_d = in_valid & fifo_full;
   assign col_inc    = 8'(col_q + 8'd1);

   assign overflow = overflow_q;
   assign tx_en    = tx_en_q;
   assign tx_data  = tx_data_q;
   assign idle     = (state_q == S_IDLE) & fifo_empty & ~flush_pend_q;

   // Character currently selected for transmission
   always_comb begin
      cur_char = 8'h20;
      case (char_q)
         C_HI:    cur_char = hex_char(byte_q[7:4]);
         C_LO:    cur_char = hex_char(byte_q[3:0]);
         C_SP:    cur_char = 8'h20;
         C_CR:    cur_char = 8'h0D;
         C_LF:    cur_char = 8'h0A;
         default: cur_char = 8'h20;
      endcase
   end

   // Next-state logic: IDLE picks flush or a FIFO byte, SEND loads the UART,
   // ARM waits for busy (with timeout), WAIT waits for the character to finish
   always_comb begin
      state_d   = state_q;
      char_d    = char_q;
      col_d     = col_q;
      arm_cnt_d = arm_cnt_q;
      tx_en_d   = 1'b0;
      tx_data_d = tx_data_q;
      flush_clr = 1'b0;
      fifo_rd   = 1'b0;
      advance   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush_pend_q) begin
               flush_clr = 1'b1;
               if (col_q != 8'd0) begin
                  col_d   = 8'd0;
                  char_d  = C_CR;
                  state_d = S_SEND;
               end
            end else if (!fifo_empty) begin
               fifo_rd = 1'b1;
               char_d  = C_HI;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (!tx_busy) begin
               tx_en_d   = 1'b1;
               tx_data_d = cur_char;
               arm_cnt_d = 2'd0;
               state_d   = S_ARM;
            end
         end
         S_ARM: begin
            if (tx_busy) begin
               state_d = S_WAIT;
            end else if (arm_cnt_q == 2'd3) begin
               // transmitter never acknowledged; treat the character as sent
               advance = 1'b1;
            end else begin
               arm_cnt_d = 2'(arm_cnt_q + 2'd1);
            end
         end
         S_WAIT: begin
            if (!tx_busy) advance = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (advance) begin
         case (char_q)
            C_HI: begin
               char_d  = C_LO;
               state_d = S_SEND;
            end
            C_LO: begin
               state_d = S_SEND;
               if (col_inc == BPL) begin
                  col_d  = 8'd0;
                  char_d = C_CR;
               end else begin
                  col_d  = col_inc;
                  char_d = C_SP;
               end
            end
            C_CR: begin
               char_d  = C_LF;
               state_d = S_SEND;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // A new flush request always wins over a same-cycle clear
   assign flush_pend_d = flush | (flush_pend_q & ~flush_clr);

   // FIFO data array: written only, read into byte_q when the FSM pops
   always_ff @(posedge clk) begin
      if (fifo_wr) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
   end

   // Popped byte register (registered read of the FIFO array)
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)      byte_q <= 8'h00;
      else if (fifo_rd) byte_q <= mem_q[rd_ptr_q[AW-1:0]];
   end

   // State, pointers and registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         state_q      <= S_IDLE;
         char_q       <= C_HI;
         col_q        <= 8'd0;
         arm_cnt_q    <= 2'd0;
         flush_pend_q <= 1'b0;
         tx_en_q      <= 1'b0;
         tx_data_q    <= 8'h00;
         overflow_q   <= 1'b0;
      end else begin
         if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (fifo_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         state_q      <= state_d;
         char_q       <= char_d;
         col_q        <= col_d;
         arm_cnt_q    <= arm_cnt_d;
         flush_pend_q <= flush_pend_d;
         tx_en_q      <= tx_en_d;
         tx_data_q    <= tx_data_d;
         overflow_q   <= overflow_d;
      end
   end

endmodule

// File: tb/tb_hex_dump_tx.sv
// tb_hex_dump_tx: randomized bench for hex_dump_tx with a UART responder and a
// character-stream reference model built from the formatting rules.
module tb_hex_dump_tx;

   localparam int DEPTH = 4;
   localparam int BPL   = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic       overflow;
   logic       flush = 1'b0;
   logic       tx_en;
   logic [7:0] tx_data;
   logic       tx_busy;
   logic       idle;

   hex_dump_tx #(.FIFO_DEPTH(DEPTH), .BYTES_PER_LINE(BPL)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .overflow (overflow),
      .flush    (flush),
      .tx_en    (tx_en),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .idle     (idle)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] exp_q[$];
   int         col_m = 0;

   function automatic logic [7:0] hexc(input int n);
      return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
   endfunction

   task automatic model_byte(input logic [7:0] b);
      exp_q.push_back(hexc(int'(b[7:4])));
      exp_q.push_back(hexc(int'(b[3:0])));
      col_m++;
      if (col_m == BPL) begin
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
         col_m = 0;
      end else begin
         exp_q.push_back(8'h20);
      end
   endtask

   task automatic model_flush();
      if (col_m != 0) begin
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
      col_m = 0;
   endtask

   // ---------------- UART responder ----------------
   int   busy_len = 6;
   logic stuck_busy = 1'b0;
   int   bcnt = 0;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_busy <= 1'b0;
         bcnt    <= 0;
      end else if (stuck_busy) begin
         tx_busy <= 1'b1;
      end else if (tx_en && busy_len > 0) begin
         tx_busy <= 1'b1;
         bcnt    <= busy_len;
      end else if (bcnt > 1) begin
         bcnt <= bcnt - 1;
      end else begin
         tx_busy <= 1'b0;
         bcnt    <= 0;
      end
   end

   // ---------------- output monitor ----------------
   logic [7:0] obs_q[$];
   int         obs_cyc[$];
   int         cyc = 0;
   int         ovf_cnt = 0;
   logic       prev_en = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(posedge clk) begin
      cyc++;
      #1;
      if (!resetn) begin
         prev_en   = 1'b0;
         prev_data = 8'h00;
      end else begin
         if (tx_en) begin
            check_eq("tx_en_single", 32'(prev_en), 32'd0);
            obs_q.push_back(tx_data);
            obs_cyc.push_back(cyc);
         end else begin
            check_eq("tx_data_hold", 32'(tx_data), 32'(prev_data));
         end
         if (overflow) ovf_cnt++;
         prev_en   = tx_en;
         prev_data = tx_data;
      end
   end

   // ---------------- stimulus helpers ----------------
   int last_wr_cyc = 0;

   task automatic push(input logic [7:0] b, input logic exp_rdy, input logic with_flush);
      @(negedge clk);
      check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
      in_valid    = 1'b1;
      in_data     = b;
      flush       = with_flush;
      last_wr_cyc = cyc + 1;
   endtask

   task automatic end_push();
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic pulse_flush();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_obs(input int cnt, input string tag);
      int n;
      n = 0;
      while (obs_q.size() < cnt && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 32'(obs_q.size() >= cnt), 32'd1);
   endtask

   task automatic wait_drain(input string tag);
      int n;
      int m;
      n = 0;
      while (!(idle && obs_q.size() >= exp_q.size()) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_drain"}, 32'(n < 5000), 32'd1);
      wait_cycles(12);
      check_eq({tag, "_idle"}, 32'(idle), 32'd1);
      check_eq({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
      m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) check_eq({tag, "_char"}, 32'(obs_q[i]), 32'(exp_q[i]));
      $display("txn %s: %0d chars expected, %0d observed", tag, exp_q.size(), obs_q.size());
      obs_q.delete();
      obs_cyc.delete();
      exp_q.delete();
   endtask

   // ---------------- main sequence ----------------
   int         nb, mode, lo_idx, ovf0, n_before;
   logic [7:0] b;
   logic [7:0] bytes4 [4];

   initial begin
      // reset state
      wait_cycles(3);
      check_eq("rst_tx_en", 32'(tx_en), 32'd0);
      check_eq("rst_tx_data", 32'(tx_data), 32'h00);
      check_eq("rst_overflow", 32'(overflow), 32'd0);
      resetn = 1'b1;
      #1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_idle", 32'(idle), 32'd1);

      // single byte, latency from write to first tx_en
      busy_len = 10;
      push(8'h3A, 1'b1, 1'b0);
      end_push();
      model_byte(8'h3A);
      wait_obs(1, "first_char_seen");
      if (obs_cyc.size() > 0)
         check_eq("latency", 32'(obs_cyc[0] - last_wr_cyc), 32'd2);
      wait_drain("single_3A");

      // flush with a partial line, then line wrap from column 0
      pulse_flush();
      model_flush();
      wait_drain("flush_partial");
      bytes4[0] = 8'h00; bytes4[1] = 8'h01; bytes4[2] = 8'hFE; bytes4[3] = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         push(bytes4[i], 1'b1, 1'b0);
         model_byte(bytes4[i]);
      end
      end_push();
      wait_drain("line_wrap");

      // flush at column 0 emits nothing
      pulse_flush();
      model_flush();
      wait_drain("flush_col0");

      // flush during the 2nd byte's LO character
      busy_len = 7;
      push(8'hA5, 1'b1, 1'b0);
      model_byte(8'hA5);
      push(8'h5C, 1'b1, 1'b0);
      lo_idx = exp_q.size() + 1;
      model_byte(8'h5C);
      end_push();
      wait_obs(lo_idx + 1, "mid_flush_lo_seen");
      pulse_flush();
      model_flush();
      wait_drain("flush_mid_byte");

      // handshake timeout: busy never asserted
      busy_len = 0;
      push(8'hC3, 1'b1, 1'b0);
      end_push();
      model_byte(8'hC3);
      wait_obs(2, "timeout_two_chars");
      if (obs_cyc.size() >= 2)
         check_eq("timeout_gap", 32'(obs_cyc[1] - obs_cyc[0]), 32'd5);
      wait_drain("timeout");

      // randomized batches
      for (int t = 0; t < 30; t++) begin
         nb       = int'($urandom_range(1, 4));
         mode     = int'($urandom_range(0, 3));
         busy_len = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
         if (mode == 3) begin
            pulse_flush();
            model_flush();
         end
         lo_idx = 0;
         for (int i = 0; i < nb; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i == 0 && mode == 1) begin
               push(b, 1'b1, 1'b1);
               model_flush();
            end else begin
               push(b, 1'b1, 1'b0);
            end
            lo_idx = exp_q.size() + 1;
            model_byte(b);
         end
         end_push();
         if (mode == 2) begin
            wait_obs(lo_idx + 1, "rand_lo_seen");
            pulse_flush();
            model_flush();
         end
         wait_drain($sformatf("rand%0d_m%0d_n%0d", t, mode, nb));
      end

      // overflow: FSM parked in SEND, FIFO fills, extra writes dropped
      busy_len = 5;
      @(negedge clk);
      stuck_busy = 1'b1;
      wait_cycles(2);
      push(8'h10, 1'b1, 1'b0);
      end_push();
      model_byte(8'h10);
      wait_cycles(3);
      ovf0 = ovf_cnt;
      for (int k = 0; k < 6; k++) begin
         b = 8'(8'h20 + k);
         push(b, (k < DEPTH) ? 1'b1 : 1'b0, 1'b0);
         if (k < DEPTH) model_byte(b);
      end
      end_push();
      wait_cycles(2);
      check_eq("overflow_pulses", 32'(ovf_cnt - ovf0), 32'd2);
      check_eq("full_in_ready", 32'(in_ready), 32'd0);
      stuck_busy = 1'b0;
      wait_drain("overflow");

      // asynchronous reset while waiting on the transmitter
      busy_len = 8;
      push(8'h11, 1'b1, 1'b0);
      push(8'h22, 1'b1, 1'b0);
      push(8'h33, 1'b1, 1'b0);
      end_push();
      wait_obs(1, "reset_first_char");
      begin
         int n;
         n = 0;
         while (!tx_busy && n < 200) begin
            @(negedge clk);
            n++;
         end
      end
      @(negedge clk);
      n_before = obs_q.size();
      #2;
      resetn = 1'b0;
      #1;
      check_eq("midrst_tx_en", 32'(tx_en), 32'd0);
      check_eq("midrst_tx_data", 32'(tx_data), 32'h00);
      check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
      wait_cycles(3);
      resetn = 1'b1;
      #1;
      check_eq("postrst_idle", 32'(idle), 32'd1);
      wait_cycles(60);
      check_eq("postrst_silent", 32'(obs_q.size()), 32'(n_before));
      check_eq("postrst_idle_late", 32'(idle), 32'd1);
      $display("txn reset_mid_char: %0d chars before reset, %0d after", n_before, obs_q.size());
      obs_q.delete();
      obs_cyc.delete();
      exp_q.delete();
      col_m = 0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
